// File: rtl/ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0_pkg.sv
// Floating-point common constants and helpers shared by the
// APM post-adder normalize/round stages.
package ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0_pkg;

  localparam int IN_WIDTH      = 48;
  localparam int MAN_WIDTH     = 23;
  localparam int LZC_WIDTH     = 6;
  // must hold -(IN_WIDTH-1) .. +1 as a signed value
  localparam int EXP_ADJ_WIDTH = 7;

  function automatic logic rne_up(
    input logic g,
    input logic s,
    input logic l
  );
    return g & (s | l);
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0_if.sv
// Sample-in / result-out bundle of the APM normalize-round stage.
// No back-pressure: the producer never waits.
interface ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0_if;
  import ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0_pkg::*;

  logic                     i_valid;
  logic [IN_WIDTH-1:0]      i_p;
  logic                     o_valid;
  logic                     o_sign;
  logic [MAN_WIDTH:0]       o_man;
  logic [EXP_ADJ_WIDTH-1:0] o_exp_adj;
  logic                     o_zero;

  modport master (
    output i_valid, i_p,
    input  o_valid, o_sign, o_man, o_exp_adj, o_zero
  );

  modport slave (
    input  i_valid, i_p,
    output o_valid, o_sign, o_man, o_exp_adj, o_zero
  );

endinterface

// File: rtl/ipsxe_floating_point_lzc48_v1_0.sv
// Combinational 48-bit leading-zero counter with all-zero flag.
// Count is 0 when the input is all zero.
module ipsxe_floating_point_lzc48_v1_0
  import ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0_pkg::*;
(
  input  logic [IN_WIDTH-1:0]  i_d,
  output logic [LZC_WIDTH-1:0] o_cnt,
  output logic                 o_zero
);

  logic w_found;

  always_comb begin
    o_cnt   = '0;
    w_found = 1'b0;
    for (int i = IN_WIDTH - 1; i >= 0; i--) begin
      if (!w_found && i_d[i]) begin
        o_cnt   = LZC_WIDTH'(IN_WIDTH - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  assign o_zero = ~|i_d;

endmodule

// File: rtl/ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0.sv
// Normalize and RNE-round the raw two's-complement APM P result.
// Fixed 3-stage pipeline: magnitude, normalize, round.
module ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0
  import ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0_if.slave bus
);

  localparam int MW1 = MAN_WIDTH + 1;
  localparam int GB  = IN_WIDTH - 1 - MW1;

  logic                 r1_valid, r1_sign, r1_zero;
  logic [IN_WIDTH-1:0]  r1_mag;
  logic                 r2_valid, r2_sign, r2_zero;
  logic [IN_WIDTH-1:0]  r2_norm;
  logic [LZC_WIDTH-1:0] r2_lzc;

  logic [LZC_WIDTH-1:0]     w_lzc;
  logic                     w_lzc_zero;
  logic [MAN_WIDTH:0]       w_m;
  logic                     w_g, w_s, w_up, w_cy;
  logic [MW1:0]             w_sum;
  logic [MAN_WIDTH:0]       w_man;
  logic [EXP_ADJ_WIDTH-1:0] w_exp;

  // -2^47 negates to itself, which read unsigned is the right magnitude
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_zero  <= 1'b0;
      r1_mag   <= '0;
    end else begin
      r1_valid <= bus.i_valid;
      r1_sign  <= bus.i_p[IN_WIDTH-1];
      r1_zero  <= ~|bus.i_p;
      r1_mag   <= bus.i_p[IN_WIDTH-1] ? -bus.i_p : bus.i_p;
    end
  end

  ipsxe_floating_point_lzc48_v1_0 u_lzc (
    .i_d    (r1_mag),
    .o_cnt  (w_lzc),
    .o_zero (w_lzc_zero)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_zero  <= 1'b0;
      r2_lzc   <= '0;
      r2_norm  <= '0;
    end else begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign;
      r2_zero  <= r1_zero | w_lzc_zero;
      r2_lzc   <= w_lzc;
      r2_norm  <= r1_mag << w_lzc;
    end
  end

  assign w_m   = r2_norm[IN_WIDTH-1 -: MW1];
  assign w_g   = r2_norm[GB];
  assign w_s   = |r2_norm[GB-1:0];
  assign w_up  = rne_up(w_g, w_s, w_m[0]);
  assign w_sum = {1'b0, w_m} + {{MW1{1'b0}}, w_up};
  assign w_cy  = w_sum[MW1];

  // carry-out only happens from all ones, so the result is exactly 1.0
  assign w_man = w_cy ? {1'b1, {MAN_WIDTH{1'b0}}}
                      : w_sum[MAN_WIDTH:0];
  assign w_exp = EXP_ADJ_WIDTH'(w_cy)
               - EXP_ADJ_WIDTH'(r2_lzc);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid   <= 1'b0;
      bus.o_sign    <= 1'b0;
      bus.o_man     <= '0;
      bus.o_exp_adj <= '0;
      bus.o_zero    <= 1'b0;
    end else begin
      bus.o_valid   <= r2_valid;
      bus.o_zero    <= r2_zero;
      bus.o_sign    <= r2_zero ? 1'b0 : r2_sign;
      bus.o_man     <= r2_zero ? '0 : w_man;
      bus.o_exp_adj <= r2_zero ? '0 : w_exp;
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0.sv
// Scoreboard bench for the APM normalize/RNE-round stage.
// Expected results come from an independent shift-and-round model.
module tb_ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0;

  typedef struct {
    logic        sign;
    logic [23:0] man;
    logic [6:0]  exp;
    logic        zero;
    longint      t;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   n_out = 0;
  int   run = 0;
  int   max_run = 0;
  exp_t sb[$];

  ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0_if u_if();

  ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0 dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [47:0] p);
    exp_t        e;
    logic [47:0] mag, trunc, rem, half;
    int          msb, sh;
    logic        up;
    e.t    = $time;
    e.zero = (p == 48'd0);
    e.sign = e.zero ? 1'b0 : p[47];
    e.man  = '0;
    e.exp  = '0;
    if (!e.zero) begin
      mag = p[47] ? (~p + 48'd1) : p;
      msb = 0;
      for (int i = 0; i < 48; i++)
        if (mag[i]) msb = i;
      e.exp = 7'(msb - 47);
      if (msb <= 23) begin
        e.man = 24'(mag << (23 - msb));
      end else begin
        sh    = msb - 23;
        trunc = mag >> sh;
        rem   = mag & ((48'd1 << sh) - 48'd1);
        half  = 48'd1 << (sh - 1);
        up    = (rem > half) || (rem == half && trunc[0]);
        trunc = trunc + {47'd0, up};
        if (trunc[24]) begin
          e.man = 24'h800000;
          e.exp = 7'(msb - 46);
        end else begin
          e.man = trunc[23:0];
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [47:0] act,
                     input logic [47:0] req);
    checks++;
    assert (act === req) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, act, req);
    end
  endtask

  task automatic send(input logic [47:0] p);
    @(negedge clk);
    u_if.i_valid = 1'b1;
    u_if.i_p     = p;
    sb.push_back(model(p));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      u_if.i_valid = 1'b0;
      u_if.i_p     = '0;
    end
  endtask

  task automatic drain();
    int k = 0;
    idle(1);
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    idle(1);
    chk("drain", 48'(sb.size()), 48'd0);
  endtask

  function automatic logic [47:0] rnd();
    logic [47:0] v;
    v = 48'({$urandom(), $urandom()});
    v = v >> $urandom_range(0, 47);
    if ($urandom_range(0, 1) == 1) v = ~v + 48'd1;
    return v;
  endfunction

  initial begin
    exp_t e;
    int   n0;
    u_if.i_valid = 1'b0;
    u_if.i_p     = '0;

    #12;
    chk("rst_valid", 48'(u_if.o_valid), 48'd0);
    chk("rst_sign", 48'(u_if.o_sign), 48'd0);
    chk("rst_man", 48'(u_if.o_man), 48'd0);
    chk("rst_exp", 48'(u_if.o_exp_adj), 48'd0);
    chk("rst_zero", 48'(u_if.o_zero), 48'd0);
    @(negedge clk);
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst && u_if.o_valid) begin
          run++;
          if (run > max_run) max_run = run;
          checks++;
          assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_valid got=1 want=0");
          end
          if (sb.size() != 0) begin
            e = sb.pop_front();
            n_out++;
            chk("latency", 48'($time - e.t), 48'd30);
            chk("sign", 48'(u_if.o_sign), 48'(e.sign));
            chk("man", 48'(u_if.o_man), 48'(e.man));
            chk("exp_adj", 48'(u_if.o_exp_adj), 48'(e.exp));
            chk("zero", 48'(u_if.o_zero), 48'(e.zero));
          end
        end else begin
          run = 0;
        end
      end
    join_none

    send(48'h000000000001);
    idle(4);
    send(48'h800000000000);
    send(48'h400000C00000);
    send(48'h400000400000);
    send(48'h400000400001);
    send(48'h7FFFFFC00000);
    send(48'h000000000000);
    send(48'hFFFFFFFFFFFF);
    send(48'hFFFFFF400000);
    send(48'h000000FFFFFF);
    drain();

    max_run = 0;
    n0 = n_out;
    for (int i = 0; i < 10; i++) send(rnd());
    drain();
    chk("burst_count", 48'(n_out - n0), 48'd10);
    chk("burst_run", 48'(max_run), 48'd10);

    for (int i = 0; i < 5; i++) send(rnd());
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 48'(u_if.o_valid), 48'd0);
    chk("arst_man", 48'(u_if.o_man), 48'd0);
    chk("arst_exp", 48'(u_if.o_exp_adj), 48'd0);
    sb.delete();
    idle(2);
    rst = 1'b0;
    n0 = n_out;
    idle(8);
    chk("no_stale", 48'(n_out - n0), 48'd0);

    send(48'hC00000000000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0.md
Name: ipsxe_floating_point_a0lo_a1y_norm_rne_v1_0

Overview:
- Consumer end of the APM post-adder path: takes the raw 48-bit two's-complement result of a0_lo ± a1*y from the APM `P` output.
- Produces sign, normalized and round-to-nearest-even mantissa, exponent adjustment and zero flag for the invsqrt/reciprocal datapath.
- Fixed 3-stage valid-qualified pipeline, no back-pressure; the APM cannot stall.

Parameters:
- IN_WIDTH, 48, width of the APM P result (two's complement); fixed by the APM.
- MAN_WIDTH, 23, output fraction width; output mantissa is MAN_WIDTH+1 bits including the hidden one.
- EXP_ADJ_WIDTH, 7, width of the signed exponent adjustment; must hold -(IN_WIDTH-1)..+1.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; asynchronous, active-high.
- i_valid  input  1  i_p is valid this cycle.
- i_p  input  IN_WIDTH  APM result, two's complement.
- o_valid  output  1  outputs valid; equals i_valid delayed 3 cycles.
- o_sign  output  1  i_p[IN_WIDTH-1] of the accepted sample.
- o_man  output  MAN_WIDTH+1  normalized, RNE-rounded magnitude; MSB=1 unless o_zero.
- o_exp_adj  output  EXP_ADJ_WIDTH  signed: -lzc, plus 1 on rounding carry-out.
- o_zero  output  1  input was exactly zero.

Behaviour:
- Reset (async, active-high): all pipeline valids, o_valid, o_sign, o_man, o_exp_adj and o_zero go to 0 immediately. Samples in flight are discarded; no o_valid pulse follows reset release unless new i_valid arrives.
- Data registers load every cycle. Valid bits shift every cycle. Outputs are only meaningful when o_valid=1.
- Stage 1 (register at edge after i_valid):
  - sign = i_p[MSB].
  - mag = sign ? -i_p : i_p, as an unsigned IN_WIDTH-bit value. -2^47 gives mag = 0x800000000000 (no overflow, since magnitude ≤ 2^47).
  - zero = (i_p == 0).
- Stage 2:
  - lzc = leading-zero count of mag, 0..IN_WIDTH-1; forced to 0 when zero.
  - norm = mag << lzc, so norm[IN_WIDTH-1] = 1 for nonzero input.
- Stage 3:
  - m = norm[IN_WIDTH-1 -: MAN_WIDTH+1].
  - Guard G = next bit below m; sticky S = OR of all remaining lower bits; L = m[0].
  - Round up iff G & (S | L).
  - If the rounded value carries out (m all ones), o_man = 1 followed by MAN_WIDTH zeros and o_exp_adj = -lzc + 1. Otherwise o_man = rounded m and o_exp_adj = -lzc.
  - If zero: o_man = 0, o_exp_adj = 0, o_zero = 1, o_sign = 0.
- Latency: exactly 3 cycles, i_valid to o_valid. Throughput: 1 sample per cycle; back-to-back valids produce back-to-back outputs with no bubbles.
- i_valid=0 cycles propagate as o_valid=0; data fields in those cycles are don't-care.
- No internal state beyond the pipeline; no FSM. Behaviour is identical for every sample regardless of history.

Decomposition:
- Shared package/header (floating-point common):
  - APM P width constant (48).
  - RNE decision function (G, S, L → round-up).
  - EXP_ADJ width rule.
- Natural sub-module: ipsxe_floating_point_lzc48_v1_0. Combinational leading-zero counter, 48-bit input, 6-bit count output, plus an all-zero flag. Reused by other normalize stages.
- Shifter, rounding and valid pipeline stay in this module.

Test Plan:
- i_p=0x000000000001, valid one cycle → 3 cycles later: o_valid=1, o_sign=0, o_man=0x800000, o_exp_adj=-47, o_zero=0.
- i_p=0x800000000000 (most negative) → o_sign=1, o_man=0x800000, o_exp_adj=0.
- RNE cases:
  - i_p=0x400000C00000 (tie, L=1) → o_man=0x800002, o_exp_adj=-1.
  - i_p=0x400000400000 (tie, L=0) → o_man=0x800000, o_exp_adj=-1.
  - i_p=0x400000400001 (above half) → o_man=0x800001.
- Round carry-out: i_p=0x7FFFFFC00000 → o_man=0x800000, o_exp_adj=0, o_sign=0.
- Zero: i_p=0 → o_zero=1, o_man=0, o_exp_adj=0, o_sign=0.
- Pipeline/reset:
  - 10 back-to-back valids with random i_p → 10 consecutive o_valid, results match the reference model in order.
  - Assert i_rst asynchronously mid-burst → o_valid drops the same instant and no stale outputs appear after release.
